// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions for the decode stage, pipeline buffers and
// the hazard/stall controller.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned MEM_LATENCY = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID-stage instruction that reads the register a load in EX has not
// yet fetched from memory.
module load_use_detector #(
    parameter int unsigned REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_src_addr,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_uses_src,
    input  logic                  id_uses_dst,
    input  logic                  ex_mem_read,
    input  logic                  ex_write_back,
    input  logic [REG_ADDR_W-1:0] ex_write_addr,
    output logic                  hazard
);

    logic src_match;
    logic dst_match;

    assign src_match = id_uses_src && (id_src_addr == ex_write_addr);
    assign dst_match = id_uses_dst && (id_dst_addr == ex_write_addr);
    assign hazard    = ex_mem_read && ex_write_back && (src_match || dst_match);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, data-memory
// freezes, buffer enables and a saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int unsigned REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int unsigned MEM_LATENCY = pipeline_ctrl_pkg::MEM_LATENCY,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_src_addr,
    input  logic [REG_ADDR_W-1:0]  id_dst_addr,
    input  logic                   id_uses_src,
    input  logic                   id_uses_dst,
    input  logic                   ex_mem_read,
    input  logic                   ex_write_back,
    input  logic [REG_ADDR_W-1:0]  ex_write_addr,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_write,
    output logic                   idex_bubble,
    output logic                   exmem_write,
    output logic                   memwb_bubble,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    import pipeline_ctrl_pkg::state_e;
    import pipeline_ctrl_pkg::RUN;
    import pipeline_ctrl_pkg::MEM_WAIT;

    localparam int unsigned CNT_W    = $clog2(MEM_LATENCY) + 1;
    localparam bit          MEM_EN   = (MEM_LATENCY > 1);
    localparam bit          MEM_LONG = (MEM_LATENCY > 2);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   mem_done;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   hazard;
    logic                   freeze_start;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detector (
        .id_src_addr   (id_src_addr),
        .id_dst_addr   (id_dst_addr),
        .id_uses_src   (id_uses_src),
        .id_uses_dst   (id_uses_dst),
        .ex_mem_read   (ex_mem_read),
        .ex_write_back (ex_write_back),
        .ex_write_addr (ex_write_addr),
        .hazard        (hazard)
    );

    always_comb begin
        freeze_start = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        busy         = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (state == MEM_WAIT || (mem_req && !mem_done && MEM_EN)) begin
            // Whole-pipeline freeze; only MEM/WB is fed a NOP.
            freeze_start = (state == RUN);
            busy         = (state == MEM_WAIT);
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            mem_done  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            mem_done <= 1'b0;
            if (!pc_write && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + STALL_ONE;
            end
            case (state)
                RUN: begin
                    if (freeze_start) begin
                        cnt <= CNT_INIT;
                        if (MEM_LONG) begin
                            state <= MEM_WAIT;
                        end else begin
                            mem_done <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    // Last freeze cycle: the next RUN cycle lets the access retire.
                    if (cnt == CNT_ONE) begin
                        state    <= RUN;
                        mem_done <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed checks of hazard_stall_controller against a
// cycle-level reference model of the sequencing rules.
module tb_hazard_stall_controller;

    localparam int LAT = 5;
    localparam int SCW = 4;
    localparam int SAT = (1 << SCW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     id_src_addr, id_dst_addr, ex_write_addr;
    logic           id_uses_src, id_uses_dst, ex_mem_read, ex_write_back;
    logic           branch_taken, mem_req;
    logic           pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic           exmem_write, memwb_bubble, busy;
    logic [SCW-1:0] stall_cycles;
    logic [7:0]     dut_outs;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: freeze cycles still to come, retire-cycle flag, stall count.
    int frz_left = 0;
    bit done     = 1'b0;
    int sc       = 0;

    hazard_stall_controller #(
        .REG_ADDR_W  (3),
        .MEM_LATENCY (LAT),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_src_addr   (id_src_addr),
        .id_dst_addr   (id_dst_addr),
        .id_uses_src   (id_uses_src),
        .id_uses_dst   (id_uses_dst),
        .ex_mem_read   (ex_mem_read),
        .ex_write_back (ex_write_back),
        .ex_write_addr (ex_write_addr),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_write    (idex_write),
        .idex_bubble   (idex_bubble),
        .exmem_write   (exmem_write),
        .memwb_bubble  (memwb_bubble),
        .busy          (busy),
        .stall_cycles  (stall_cycles)
    );

    assign dut_outs = {pc_write, ifid_write, ifid_flush, idex_write,
                       idex_bubble, exmem_write, memwb_bubble, busy};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble, busy}
    function automatic logic [7:0] exp_out();
        bit hz, frozen;
        if (rst) return 8'b0010_1010;
        frozen = (frz_left > 0) || (mem_req && !done && LAT > 1);
        if (frozen) return {7'b0000_001, (frz_left > 0)};
        hz = ex_mem_read && ex_write_back &&
             ((id_uses_src && id_src_addr == ex_write_addr) ||
              (id_uses_dst && id_dst_addr == ex_write_addr));
        if (branch_taken) return 8'b1111_1100;
        if (hz)           return 8'b0001_1100;
        return 8'b1101_0100;
    endfunction

    task automatic model_reset();
        frz_left = 0;
        done     = 1'b0;
        sc       = 0;
    endtask

    task automatic model_update();
        logic [7:0] e;
        if (rst) begin
            model_reset();
            return;
        end
        e = exp_out();
        if (!e[7] && sc < SAT) sc++;
        if (frz_left > 0) begin
            frz_left--;
            done = (frz_left == 0);
        end else if (mem_req && !done && LAT > 1) begin
            frz_left = LAT - 2;
            done     = (frz_left == 0);
        end else begin
            done = 1'b0;
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check({tag, " outs"}, {24'b0, dut_outs}, {24'b0, exp_out()});
        check({tag, " stalls"}, 32'(stall_cycles), 32'(sc));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        id_src_addr   = 3'd0;
        id_dst_addr   = 3'd0;
        ex_write_addr = 3'd0;
        id_uses_src   = 1'b0;
        id_uses_dst   = 1'b0;
        ex_mem_read   = 1'b0;
        ex_write_back = 1'b0;
        branch_taken  = 1'b0;
        mem_req       = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read   = 1'b1;
        ex_write_back = 1'b1;
        ex_write_addr = 3'd3;
        id_uses_src   = 1'b1;
        id_src_addr   = 3'd3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        cycle("rst");
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        cycle("idle");

        // Load-use stall, then the same fields with the source unused.
        set_load_use();
        cycle("lu");
        id_uses_src = 1'b0;
        cycle("lu_nosrc");
        idle_inputs();

        // Taken branch alone.
        branch_taken = 1'b1;
        cycle("br");
        branch_taken = 1'b0;
        cycle("br_after");

        // Continuous mem_req: 4 freeze, 1 retire, new freeze.
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cycle("frz_a");
        check("frz_cnt4", 32'(stall_cycles), 32'd4);
        cycle("frz_done");
        for (int i = 0; i < 5; i++) cycle("frz_b");
        idle_inputs();
        cycle("frz_exit");

        // Freeze beats branch and load-use; branch resolves in the retire cycle.
        do_reset();
        set_load_use();
        branch_taken = 1'b1;
        mem_req      = 1'b1;
        for (int i = 0; i < 4; i++) cycle("sim_frz");
        mem_req = 1'b0;
        @(negedge clk);
        check("sim_done_outs", {24'b0, dut_outs}, 32'h0000_00FC);
        @(posedge clk);
        model_update();
        #1;
        idle_inputs();
        cycle("sim_after");

        // Reset on the second freeze cycle.
        do_reset();
        mem_req = 1'b1;
        cycle("rmw0");
        mem_req = 1'b0;
        rst     = 1'b1;
        #1;
        model_reset();
        check("rmw_outs", {24'b0, dut_outs}, 32'h0000_002A);
        check("rmw_stalls", 32'(stall_cycles), 32'd0);
        cycle("rmw_hold");
        rst = 1'b0;
        cycle("rmw_run");

        // Saturation under sustained load-use.
        do_reset();
        set_load_use();
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat_final", 32'(stall_cycles), 32'(SAT));
        idle_inputs();

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_src_addr   = 3'($urandom_range(0, 3));
            id_dst_addr   = 3'($urandom_range(0, 3));
            ex_write_addr = 3'($urandom_range(0, 3));
            id_uses_src   = 1'($urandom_range(0, 1));
            id_uses_dst   = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            ex_write_back = 1'($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            mem_req       = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
